// File: rtl/prog_loader_pkg.sv
// Shared widths, write-enable pattern and state encoding for the program loader.
package prog_loader_pkg;
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 18;
  localparam logic [3:0] WE_INSTR = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    B0,
    B1,
    B2,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_e;
endpackage

// File: rtl/prog_loader.sv
// Receives an 18-bit instruction image as 3 bytes per word plus a trailing checksum,
// writes it into program memory and holds the processor in reset until it verifies.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  word_count,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [ADDR_W-1:0]  cpu_address,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic [3:0]         mem_we,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [7:0]          sum_q, sum_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                rx_ready_q, busy_q, done_q, err_q, cpu_reset_q;
  logic [3:0]          mem_we_q;
  logic                fire;

  assign fire = rx_valid && rx_ready_q;

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    last_d      = last_q;
    sum_d       = sum_q;
    instr_d     = instr_q;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d     = B0;
          load_addr_d = '0;
          sum_d       = '0;
          last_d      = word_count;
        end
      end
      B0: begin
        if (fire) begin
          sum_d = sum_q + rx_data;
          if (rx_data[7:2] != 6'd0) begin
            state_d = ERR;
          end else begin
            instr_d[17:16] = rx_data[1:0];
            state_d        = B1;
          end
        end
      end
      B1: begin
        if (fire) begin
          sum_d         = sum_q + rx_data;
          instr_d[15:8] = rx_data;
          state_d       = B2;
        end
      end
      B2: begin
        if (fire) begin
          sum_d        = sum_q + rx_data;
          instr_d[7:0] = rx_data;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        // last never exceeds 1023, so the increment cannot wrap inside a load
        if (load_addr_q == last_q) begin
          state_d = CSUM;
        end else begin
          load_addr_d = load_addr_q + 1'b1;
          state_d     = B0;
        end
      end
      CSUM: begin
        if (fire) begin
          state_d = (rx_data == sum_q) ? DONE : ERR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      load_addr_q <= '0;
      last_q      <= '0;
      sum_q       <= '0;
      instr_q     <= '0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b0;
      mem_we_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      last_q      <= last_d;
      sum_q       <= sum_d;
      instr_q     <= instr_d;
      rx_ready_q  <= (state_d inside {B0, B1, B2, CSUM});
      busy_q      <= (state_d inside {B0, B1, B2, WRITE, CSUM});
      done_q      <= (state_d == DONE);
      err_q       <= (state_d == ERR);
      cpu_reset_q <= !(state_d inside {IDLE, DONE});
      mem_we_q    <= (state_d == WRITE) ? WE_INSTR : 4'b0000;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_reset = cpu_reset_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = instr_q;
  assign mem_addr  = busy_q ? load_addr_q : cpu_address;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte-stream loads with hand-computed writes and checksums.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  word_count = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [9:0]  cpu_address = '0;
  logic [9:0]  mem_addr;
  logic [17:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        cpu_reset, busy, done, err;

  int checks = 0;
  int errors = 0;

  int          wr_cnt = 0;
  int          we_bad = 0;
  int          done_cnt = 0;
  logic [9:0]  last_addr = '0;
  logic [17:0] mem_model [0:1023];
  int          addr_hits [0:1023];

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cpu_address(cpu_address), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_model[i] = '0;
      addr_hits[i] = 0;
    end
  end

  // Write/done observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we !== 4'b0000) begin
      wr_cnt++;
      if (mem_we !== 4'b0011) we_bad++;
      if (!$isunknown(mem_addr)) begin
        mem_model[mem_addr] = mem_wdata;
        addr_hits[mem_addr]++;
      end
      last_addr = mem_addr;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [9:0] wc);
    start = 1'b1;
    word_count = wc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte after `gap` idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data = b;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (rx_ready) ok = 1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic word_bytes(input int i, output logic [7:0] b0, output logic [7:0] b1,
                            output logic [7:0] b2);
    logic [9:0] a;
    a  = i[9:0];
    b0 = {6'd0, a[1:0]};
    b1 = a[9:2];
    b2 = ~a[7:0];
  endtask

  // Stream from the basic two-word example, optionally with gaps and a stray start.
  task automatic basic_load(input logic [7:0] csum, input int gap, input bit stray_start);
    logic [7:0] s [0:5];
    s[0] = 8'h01; s[1] = 8'h23; s[2] = 8'h45; s[3] = 8'h00; s[4] = 8'hAB; s[5] = 8'hCD;
    for (int k = 0; k < 6; k++) begin
      send_byte(s[k], gap);
      if (stray_start && k == 2) pulse_start(10'd7);
    end
    send_byte(csum, gap);
  endtask

  int          base_wr, base_done, base_hit0, base_hit5;
  logic [7:0]  b0, b1, b2, sum;
  logic [17:0] exp_w;

  initial begin
    reset = 1'b1;
    idle(2);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cpu_reset", cpu_reset, 0);
    check("rst_mem_we", mem_we, 0);
    cpu_address = 10'h2A5;
    #1 check("rst_mem_addr_mux", mem_addr, 10'h2A5);
    reset = 1'b0;
    idle(1);

    // Good two-word load
    base_wr = wr_cnt; base_done = done_cnt;
    pulse_start(10'd1);
    check("a_busy", busy, 1);
    check("a_cpu_reset_on", cpu_reset, 1);
    check("a_rx_ready", rx_ready, 1);
    basic_load(8'hE1, 0, 0);
    idle(3);
    check("a_writes", wr_cnt - base_wr, 2);
    check("a_word0", mem_model[0], 18'h12345);
    check("a_word1", mem_model[1], 18'h0ABCD);
    check("a_done", done_cnt - base_done, 1);
    check("a_cpu_reset_off", cpu_reset, 0);
    check("a_err", err, 0);
    check("a_busy_end", busy, 0);
    $display("load A: wc=1 csum=E1 writes=%0d done=%0d err=%0b", wr_cnt - base_wr,
             done_cnt - base_done, err);

    // Bad checksum
    base_wr = wr_cnt; base_done = done_cnt;
    pulse_start(10'd1);
    basic_load(8'hE2, 0, 0);
    idle(3);
    check("b_writes", wr_cnt - base_wr, 2);
    check("b_err", err, 1);
    check("b_cpu_reset", cpu_reset, 1);
    check("b_done", done_cnt - base_done, 0);
    $display("load B: wc=1 csum=E2 writes=%0d done=%0d err=%0b", wr_cnt - base_wr,
             done_cnt - base_done, err);

    // Malformed first byte, started from ERR
    base_wr = wr_cnt;
    pulse_start(10'd1);
    check("c_err_cleared", err, 0);
    send_byte(8'h04, 0);
    check("c_err", err, 1);
    check("c_rx_ready", rx_ready, 0);
    check("c_busy", busy, 0);
    idle(3);
    check("c_writes", wr_cnt - base_wr, 0);
    check("c_cpu_reset", cpu_reset, 1);
    $display("load C: first byte 04 writes=%0d err=%0b", wr_cnt - base_wr, err);

    // Sparse rx_valid plus an ignored start mid-load
    mem_model[0] = '0; mem_model[1] = '0;
    base_wr = wr_cnt; base_done = done_cnt;
    pulse_start(10'd1);
    basic_load(8'hE1, 2, 1);
    idle(3);
    check("d_writes", wr_cnt - base_wr, 2);
    check("d_word0", mem_model[0], 18'h12345);
    check("d_word1", mem_model[1], 18'h0ABCD);
    check("d_done", done_cnt - base_done, 1);
    check("d_err", err, 0);
    $display("load D: sparse+stray start writes=%0d done=%0d", wr_cnt - base_wr,
             done_cnt - base_done);

    // Reset while in B1 of word 5
    base_wr = wr_cnt; base_hit5 = addr_hits[5];
    pulse_start(10'd9);
    for (int i = 0; i < 5; i++) begin
      word_bytes(i, b0, b1, b2);
      send_byte(b0, 0); send_byte(b1, 0); send_byte(b2, 0);
    end
    word_bytes(5, b0, b1, b2);
    send_byte(b0, 0);
    cpu_address = 10'h155;
    reset = 1'b1;
    #1;
    check("e_busy", busy, 0);
    check("e_rx_ready", rx_ready, 0);
    check("e_cpu_reset", cpu_reset, 0);
    check("e_mem_we", mem_we, 0);
    check("e_err", err, 0);
    check("e_mem_addr", mem_addr, 10'h155);
    idle(2);
    reset = 1'b0;
    idle(3);
    check("e_writes", wr_cnt - base_wr, 5);
    check("e_no_write_5", addr_hits[5] - base_hit5, 0);
    word_bytes(4, b0, b1, b2);
    check("e_word4", mem_model[4], {b0[1:0], b1, b2});
    $display("load E: reset in word5 writes=%0d", wr_cnt - base_wr);

    // Full 1024-word load
    base_wr = wr_cnt; base_done = done_cnt; base_hit0 = addr_hits[0];
    sum = 8'h00;
    pulse_start(10'd1023);
    for (int i = 0; i < 1024; i++) begin
      word_bytes(i, b0, b1, b2);
      sum = sum + b0 + b1 + b2;
      send_byte(b0, 0); send_byte(b1, 0); send_byte(b2, 0);
    end
    send_byte(sum, 0);
    idle(3);
    check("f_writes", wr_cnt - base_wr, 1024);
    check("f_last_addr", last_addr, 10'h3FF);
    check("f_hits0", addr_hits[0] - base_hit0, 1);
    word_bytes(1023, b0, b1, b2);
    exp_w = {b0[1:0], b1, b2};
    check("f_word3ff", mem_model[10'h3FF], exp_w);
    word_bytes(512, b0, b1, b2);
    exp_w = {b0[1:0], b1, b2};
    check("f_word200", mem_model[10'h200], exp_w);
    check("f_done", done_cnt - base_done, 1);
    check("f_err", err, 0);
    $display("load F: wc=1023 writes=%0d done=%0d", wr_cnt - base_wr, done_cnt - base_done);

    check("we_pattern", we_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL expose the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a program load.
- word_count  in  10  number of instructions to load minus one (N = word_count+1, 1..1024); sampled on the accepted start.
- rx_data  in  8  image byte stream.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- cpu_address  in  10  processor fetch address.
- mem_addr  out  10  program-memory address.
- mem_wdata  out  18  program-memory write data.
- mem_we  out  4  program-memory byte write enable.
- cpu_reset  out  1  holds the processor in reset.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on a successful load.
- err  out  1  sticky load failure.

Function
REQ-002 States SHALL be IDLE, B0, B1, B2, WRITE, CSUM, DONE, ERR.
REQ-003 Byte handshake: a byte SHALL transfer when rx_valid && rx_ready; rx_ready SHALL be 1 only in B0, B1, B2 and CSUM.
REQ-004 IDLE or ERR, start=1 -> B0: load_addr=0, sum=0, last=word_count latched, err cleared, cpu_reset=1.
REQ-005 start SHALL be ignored in every other state.
REQ-006 B0 byte: bits[7:2] SHALL be zero, else -> ERR with no write; bits[1:0] -> instr[17:16]; -> B1.
REQ-007 B1 byte -> instr[15:8], -> B2; B2 byte -> instr[7:0], -> WRITE.
REQ-008 Every accepted byte except the checksum SHALL be added to sum, mod 256.
REQ-009 WRITE lasts exactly 1 cycle: mem_we=4'b0011, mem_addr=load_addr, mem_wdata=instr.
REQ-010 Leaving WRITE: if load_addr==last -> CSUM, else load_addr+1 -> B0; load_addr SHALL never wrap to 0 within a load.
REQ-011 CSUM: an accepted byte equal to sum -> DONE, otherwise -> ERR.
REQ-012 DONE lasts 1 cycle: done=1, cpu_reset=0, then -> IDLE.
REQ-013 ERR: err=1 and cpu_reset=1 SHALL persist until the next start or reset.
REQ-014 mem_addr SHALL be load_addr while busy and cpu_address otherwise (combinational mux).
REQ-015 mem_we SHALL be 4'b0000 outside WRITE; mem_wdata is don't-care outside WRITE.
REQ-016 busy SHALL be 1 in B0, B1, B2, WRITE and CSUM.
REQ-017 Latency: minimum 4 cycles per instruction (3 bytes + WRITE); rx_valid gaps only stretch the byte states.
REQ-018 All outputs except the mem_addr mux SHALL be registered.

Reset
REQ-019 Asserting reset SHALL immediately force IDLE; rx_ready, mem_we, busy, done, err, cpu_reset=0; load_addr, sum, instr=0.
REQ-020 reset mid-load SHALL abandon the load without any further write; the memory keeps the words already written.

Structure
REQ-021 Package prog_loader_pkg SHALL hold ADDR_W=10, INSTR_W=18, WE_INSTR=4'b0011 and the state enum.
REQ-022 Single module, no sub-module.

Verification
REQ-023 word_count=1, bytes 01 23 45 00 AB CD, checksum E1 -> writes 0x12345@0x000 and 0x0ABCD@0x001, done pulse, cpu_reset 1->0, err=0.
REQ-024 Same stream with checksum E2 -> both writes occur, err=1, cpu_reset stays 1, no done pulse.
REQ-025 First byte 0x04 -> ERR after 1 byte, mem_we never asserted, err=1.
REQ-026 Case REQ-023 with rx_valid high every third cycle and a start pulse mid-load -> identical writes and result, start ignored.
REQ-027 reset asserted during B1 of word 5 -> outputs at reset values immediately, no write at 0x005, mem_addr follows cpu_address.
REQ-028 word_count=1023 with a valid checksum -> 1024 writes, last at 0x3FF, none at 0x000 after it, done pulse.
